// File: rtl/game_state_ctrl.sv
// Top-level game state register for the VGA game.
// Sequences MENU -> PLAY -> SETTLE -> MENU, with PAUSE as a side state off PLAY.
// It also owns the round countdown timer and the minimum settle-screen hold.
// It emits the one-cycle state_enter and game_clear pulses for the datapath and the renderer.
module game_state_ctrl #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int GAME_SECS      = 60,   // 1..127
  parameter int SETTLE_HOLD    = 30    // 1..255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_tick_i,
  input  logic       btn_i,
  input  logic       btn_pause_i,
  input  logic       game_over_i,
  output logic [1:0] state_o,
  output logic       state_enter_o,
  output logic       game_clear_o,
  output logic       play_en_o,
  output logic [6:0] time_left_o
);

  localparam int FCW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  typedef enum logic [1:0] {
    MENU   = 2'b00,
    PLAY   = 2'b01,
    SETTLE = 2'b10,
    PAUSE  = 2'b11
  } state_t;

  state_t         state_q;
  logic           state_enter_q;
  logic           game_clear_q;
  logic [6:0]     time_left_q;
  logic [FCW-1:0] frame_cnt_q;
  logic [7:0]     hold_cnt_q;
  logic           btn_q;
  logic           pause_q;

  logic press_d;
  logic ppress_d;
  logic hold_done_d;

  // Rising-edge detect on the buttons, plus the settle-hold expiry flag.
  always_comb begin
    press_d     = btn_i & ~btn_q;
    ppress_d    = btn_pause_i & ~pause_q;
    hold_done_d = (hold_cnt_q == 8'(SETTLE_HOLD));
  end

  // State machine, round timer, settle hold and registered pulses.
  // The button history resets high, so a button held through reset fires only after release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= MENU;
      state_enter_q <= 1'b0;
      game_clear_q  <= 1'b0;
      time_left_q   <= 7'(GAME_SECS);
      frame_cnt_q   <= '0;
      hold_cnt_q    <= '0;
      btn_q         <= 1'b1;
      pause_q       <= 1'b1;
    end else begin
      btn_q         <= btn_i;
      pause_q       <= btn_pause_i;
      state_enter_q <= 1'b0;
      game_clear_q  <= 1'b0;
      case (state_q)
        MENU: begin
          if (press_d) begin
            state_q       <= PLAY;
            state_enter_q <= 1'b1;
            game_clear_q  <= 1'b1;
            time_left_q   <= 7'(GAME_SECS);
            frame_cnt_q   <= '0;
          end
        end
        PLAY: begin
          // Leaving PLAY discards a tick that arrives in the same cycle.
          if (game_over_i || time_left_q == 7'd0) begin
            state_q       <= SETTLE;
            state_enter_q <= 1'b1;
            hold_cnt_q    <= '0;
          end else if (ppress_d) begin
            state_q       <= PAUSE;
            state_enter_q <= 1'b1;
          end else if (frame_tick_i) begin
            if (frame_cnt_q == FCW'(FRAMES_PER_SEC - 1)) begin
              frame_cnt_q <= '0;
              if (time_left_q != 7'd0) time_left_q <= time_left_q - 7'd1;
            end else begin
              frame_cnt_q <= frame_cnt_q + FCW'(1);
            end
          end
        end
        PAUSE: begin
          // A press on both buttons together yields a single return to PLAY.
          if (press_d || ppress_d) begin
            state_q       <= PLAY;
            state_enter_q <= 1'b1;
          end
        end
        SETTLE: begin
          // A press before the hold expires is dropped rather than queued.
          if (press_d && hold_done_d) begin
            state_q       <= MENU;
            state_enter_q <= 1'b1;
          end else if (frame_tick_i && !hold_done_d) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: state_q <= MENU;
      endcase
    end
  end

  assign state_o       = state_q;
  assign state_enter_o = state_enter_q;
  assign game_clear_o  = game_clear_q;
  assign play_en_o     = (state_q == PLAY);
  assign time_left_o   = time_left_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl.
// A count-based reference model is compared against the outputs every cycle.
// Hand-computed literal checks pin key points of the sequence.
module tb_game_state_ctrl;

  localparam int FPS  = 60;
  localparam int SECS = 60;
  localparam int HOLD = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, btn = 1'b1, bpause = 1'b0, gover = 1'b0;
  logic [1:0] state;
  logic       enter, gclear, play_en;
  logic [6:0] tleft;

  int checks = 0;
  int errors = 0;

  game_state_ctrl #(.FRAMES_PER_SEC(FPS), .GAME_SECS(SECS), .SETTLE_HOLD(HOLD)) dut (
    .clk_i(clk), .rst_i(rst), .frame_tick_i(tick), .btn_i(btn),
    .btn_pause_i(bpause), .game_over_i(gover),
    .state_o(state), .state_enter_o(enter), .game_clear_o(gclear),
    .play_en_o(play_en), .time_left_o(tleft)
  );

  always #5 clk = ~clk;

  // Reference model. The timer is a count of PLAY ticks since the last round start.
  // The settle hold is a count of ticks since entering SETTLE.
  localparam int M_MENU = 0, M_PLAY = 1, M_SETTLE = 2, M_PAUSE = 3;
  int  m_state = M_MENU, play_ticks = 0, settle_ticks = 0;
  bit  m_enter = 0, m_clear = 0, m_btn = 1, m_pause = 1;
  bit  chk_en = 0;

  function automatic int m_tleft();
    int t;
    t = SECS - play_ticks / FPS;
    return (t < 0) ? 0 : t;
  endfunction

  always @(posedge clk) begin
    int nxt;
    bit press, ppress;
    if (rst) begin
      m_state = M_MENU; play_ticks = 0; settle_ticks = 0;
      m_enter = 0; m_clear = 0; m_btn = 1; m_pause = 1;
      chk_en = 1;
    end else begin
      press  = btn & ~m_btn;
      ppress = bpause & ~m_pause;
      m_btn = btn; m_pause = bpause;
      nxt = m_state; m_clear = 0;
      case (m_state)
        M_MENU:   if (press) begin nxt = M_PLAY; play_ticks = 0; m_clear = 1; end
        M_PLAY:   if (gover || m_tleft() == 0) begin nxt = M_SETTLE; settle_ticks = 0; end
                  else if (ppress) nxt = M_PAUSE;
                  else if (tick) play_ticks++;
        M_PAUSE:  if (press || ppress) nxt = M_PLAY;
        default:  if (press && settle_ticks >= HOLD) nxt = M_MENU;
                  else if (tick) settle_ticks++;
      endcase
      m_enter = (nxt != m_state);
      m_state = nxt;
    end
  end

  // Compare process: every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (state !== 2'(m_state) || enter !== m_enter || gclear !== m_clear ||
          play_en !== (m_state == M_PLAY) || tleft !== 7'(m_tleft())) begin
        errors++;
        $display("FAIL model t=%0t: got st=%0d en=%0b clr=%0b pe=%0b tl=%0d, want st=%0d en=%0b clr=%0b pe=%0b tl=%0d",
                 $time, state, enter, gclear, play_en, tleft,
                 m_state, m_enter, m_clear, (m_state == M_PLAY), m_tleft());
      end
    end
  end

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin tick = 1; cyc(); tick = 0; cyc(); end
  endtask

  task automatic press_btn();
    btn = 0; cyc(); btn = 1; cyc(); btn = 0;
  endtask

  task automatic press_pause();
    bpause = 0; cyc(); bpause = 1; cyc(); bpause = 0;
  endtask

  initial begin
    // Reset with btn held, then keep it held
    rst = 1; btn = 1;
    repeat (3) cyc();
    rst = 0;
    repeat (10) begin
      cyc();
      lit("held_btn_state", state, 0);
      lit("held_btn_enter", enter, 0);
    end
    lit("reset_tleft", tleft, 60);

    // MENU ignores pause and game_over
    gover = 1; press_pause(); gover = 0; cyc();
    lit("menu_ignores", state, 0);

    // Release, then press -> PLAY with both pulses
    btn = 0; cyc(); btn = 1; cyc();
    lit("start_state", state, 1);
    lit("start_enter", enter, 1);
    lit("start_clear", gclear, 1);
    lit("start_tleft", tleft, 60);
    lit("start_play_en", play_en, 1);
    cyc();
    lit("start_enter_1cyc", enter, 0);
    lit("start_clear_1cyc", gclear, 0);
    btn = 0; cyc();

    // Timer: 60 ticks per second
    ticks(60);
    lit("tleft_after_60", tleft, 59);
    ticks(1020);
    lit("tleft_42", tleft, 42);

    // Pause freezes the timer; both buttons together -> one PLAY entry
    press_pause();
    lit("pause_state", state, 3);
    ticks(200);
    lit("pause_frozen", tleft, 42);
    btn = 1; bpause = 1; cyc();
    lit("resume_state", state, 1);
    lit("resume_enter", enter, 1);
    lit("resume_noclear", gclear, 0);
    btn = 0; bpause = 0; cyc();
    lit("resume_single", state, 1);

    // Remaining 2520 ticks run the timer to 0, then SETTLE
    ticks(2519);
    lit("tleft_1", tleft, 1);
    tick = 1; cyc(); tick = 0;
    lit("tleft_0", tleft, 0);
    lit("still_play_at_0", state, 1);
    cyc();
    lit("settle_after_0", state, 2);
    lit("settle_enter", enter, 1);

    // Settle hold: early press dropped, press after 30 ticks accepted
    ticks(10);
    press_btn();
    lit("early_press_dropped", state, 2);
    ticks(20);
    press_btn();
    lit("settle_to_menu", state, 0);
    lit("score_held", tleft, 0);
    cyc();

    // New round: game_over beats ppress
    press_btn();
    lit("round2_tleft", tleft, 60);
    ticks(100);
    gover = 1; bpause = 1; cyc(); gover = 0; bpause = 0;
    lit("gover_over_pause", state, 2);
    lit("gover_tleft", tleft, 59);
    ticks(30);
    press_btn();
    press_btn();
    press_pause();
    lit("pause_again", state, 3);

    // Reset mid-PAUSE
    rst = 1; cyc(); rst = 0;
    lit("rst_state", state, 0);
    lit("rst_tleft", tleft, 60);
    lit("rst_enter", enter, 0);
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
